// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// master = producer side, slave = transmitter side.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data LSB-first, optional parity, STOP_BITS stop bits,
// each bit held OVERSAMPLE baud_clk cycles. Parity stage is built only when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic      baud_clk,
    input  logic      reset,
    uart_tx_if.slave  bus,
    output logic      dout,
    output logic      tx_busy,
    output logic      tx_done
);

    localparam int              OS_W      = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [7:0]      DATA_MASK = 8'((1 << DATA_BITS) - 1);

    if (OVERSAMPLE < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_tx: unsupported parameter combination");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [OS_W-1:0] os_cnt_q, os_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            dout_q, dout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic bit_end;
    logic accept;
    logic last_data;
    logic last_stop;

    assign bit_end   = (os_cnt_q == OS_LAST);
    assign accept    = bus.tx_valid && (state_q == IDLE);
    assign last_data = (bit_idx_q == DATA_LAST);
    assign last_stop = (bit_idx_q == STOP_LAST);

    assign bus.tx_ready = (state_q == IDLE);
    assign dout         = dout_q;
    assign tx_busy      = busy_q;
    assign tx_done      = done_q;

    // State register; the line is forced idle-high the moment reset asserts.
    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            os_cnt_q  <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            dout_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (accept) state_d = START;
            START:  if (bit_end) state_d = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (bit_end && last_data) state_d = PARITY;
            PARITY: if (bit_end) state_d = STOP;
`else
            DATA:   if (bit_end && last_data) state_d = STOP;
`endif
            STOP:   if (bit_end && last_stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath logic; dout is registered so it changes only on bit boundaries.
    always_comb begin
        os_cnt_d  = bit_end ? '0 : os_cnt_q + OS_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                os_cnt_d  = '0;
                dout_d    = 1'b1;
                busy_d    = 1'b0;
                bit_idx_d = '0;
                if (accept) begin
                    shift_d = bus.tx_data & DATA_MASK;
                    dout_d  = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^(bus.tx_data & DATA_MASK)) ^ PARITY_ODD[0];
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    dout_d    = shift_q[0];
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (last_data) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        dout_d = parity_q;
`else
                        dout_d = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        dout_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    dout_d    = 1'b1;
                    bit_idx_d = '0;
                end
            end
`endif
            STOP: begin
                dout_d = 1'b1;
                if (bit_end) begin
                    if (last_stop) begin
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                os_cnt_d  = '0;
                bit_idx_d = '0;
                dout_d    = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table vectors, random bytes, back-to-back, mid-frame reset,
// and a behavioural receiver on dout whose decoded bytes are compared with those sent.
module tb_uart_tx;

    localparam int OS    = 16;
    localparam int DB    = 8;
    localparam int SB    = 1;
    localparam int PODD  = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int FRAME = (1 + DB + PAR_EN + SB) * OS;

    logic baud_clk;
    logic reset;
    logic dout;
    logic tx_busy;
    logic tx_done;

    uart_tx_if bus_if ();

    uart_tx #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB),
        .STOP_BITS  (SB),
        .PARITY_ODD (PODD)
    ) dut (
        .baud_clk (baud_clk),
        .reset    (reset),
        .bus      (bus_if),
        .dout     (dout),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial begin
        baud_clk = 1'b0;
        forever #5 baud_clk = ~baud_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_done_cyc = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int rx_stop_err = 0;
    int rx_par_err  = 0;

    initial forever begin
        @(posedge baud_clk);
        cyc++;
    end

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference: parity from a plain count of ones in the low DB bits.
    function automatic logic par_model(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < DB; i++) ones += int'(d[i]);
        return 1'((ones % 2) ^ PODD);
    endfunction

    // Reference: expected line level e cycles after the accept edge.
    function automatic logic exp_line(input logic [7:0] d, input logic par, input int e);
        int k = e / OS;
        if (k == 0) return 1'b0;
        if (k <= DB) return d[k-1];
        if (PAR_EN == 1 && k == DB + 1) return par;
        return 1'b1;
    endfunction

    // Behavioural receiver: mid-bit sampling after a falling edge, aborts on reset.
    initial begin
        int rx_cnt = -1;
        int k;
        logic [7:0] rx_byte = 8'h00;
        logic rx_par = 1'b0;
        forever begin
            @(negedge baud_clk);
            if (!reset) begin
                rx_cnt = -1;
            end else if (rx_cnt < 0) begin
                if (dout === 1'b0) begin
                    rx_cnt  = 0;
                    rx_byte = 8'h00;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % OS == OS / 2) begin
                    k = rx_cnt / OS;
                    if (k == 0) begin
                        if (dout !== 1'b0) rx_cnt = -1;
                    end else if (k <= DB) begin
                        rx_byte[k-1] = dout;
                    end else if (PAR_EN == 1 && k == DB + 1) begin
                        rx_par = dout;
                    end else begin
                        if (dout !== 1'b1) rx_stop_err++;
                        if (PAR_EN == 1 && rx_par !== par_model(rx_byte)) rx_par_err++;
                        rx_q.push_back(rx_byte);
                        rx_cnt = -1;
                    end
                end
            end
        end
    end

    // Called just after the accept edge; returns at the negedge where tx_done should be high.
    task automatic check_frame(input logic [7:0] d, input logic par, input bit hold,
                               input logic [7:0] hold_data, input int glitch_at);
        int bad_line = 0;
        int first_bad = -1;
        int bad_status = 0;
        logic exp;
        for (int e = 0; e <= FRAME; e++) begin
            @(negedge baud_clk);
            if (e < FRAME) begin
                exp = exp_line(d, par, e);
                if (dout !== exp) begin
                    bad_line++;
                    if (first_bad < 0) first_bad = e;
                end
                if (tx_busy !== 1'b1 || tx_done !== 1'b0 || bus_if.tx_ready !== 1'b0) bad_status++;
                if (e % OS == OS / 2) check($sformatf("bit%0d_of_%02h", e / OS, d), int'(dout), int'(exp));
            end else begin
                last_done_cyc = cyc;
                check($sformatf("done_of_%02h", d), int'(tx_done), 1);
                check($sformatf("busy_end_of_%02h", d), int'(tx_busy), 0);
                check($sformatf("ready_end_of_%02h", d), int'(bus_if.tx_ready), 1);
                check($sformatf("idle_line_of_%02h", d), int'(dout), 1);
            end
            if (e == 0) begin
                if (hold) bus_if.tx_data = hold_data;
                else begin
                    bus_if.tx_valid = 1'b0;
                    bus_if.tx_data  = 8'($urandom);
                end
            end else if (glitch_at > 0 && e == glitch_at) begin
                bus_if.tx_valid = 1'b1;
                bus_if.tx_data  = 8'hFF;
            end else if (glitch_at > 0 && e == glitch_at + 1) begin
                bus_if.tx_valid = 1'b0;
            end else if (!hold && e < FRAME) begin
                bus_if.tx_data = 8'($urandom);
            end
        end
        check($sformatf("line_bad_cycles_%02h(first %0d)", d, first_bad), bad_line, 0);
        check($sformatf("status_bad_cycles_%02h", d), bad_status, 0);
    endtask

    task automatic send(input logic [7:0] d, input logic par, input int glitch_at);
        int n = 0;
        @(negedge baud_clk);
        while (bus_if.tx_ready !== 1'b1 && n < 2000) begin
            @(negedge baud_clk);
            n++;
        end
        if (n >= 2000) begin
            check("ready_timeout", 0, 1);
            return;
        end
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = d;
        @(posedge baud_clk);
        check_frame(d, par, 1'b0, 8'h00, glitch_at);
        tx_q.push_back(d);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_even;
        int         glitch_at;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int done1;
        int bad_done;
        logic [7:0] d;

        tbl[0] = '{8'h55, 1'b0, -1};
        tbl[1] = '{8'hA5, 1'b0, -1};
        tbl[2] = '{8'h07, 1'b1, -1};
        tbl[3] = '{8'h80, 1'b1, 40};
        tbl[4] = '{8'h01, 1'b1, -1};
        tbl[5] = '{8'h3C, 1'b0, 40};
        tbl[6] = '{8'hFE, 1'b1, -1};

        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = 8'h00;
        reset = 1'b0;
        repeat (3) @(negedge baud_clk);
        check("reset_dout", int'(dout), 1);
        check("reset_busy", int'(tx_busy), 0);
        check("reset_done", int'(tx_done), 0);
        check("reset_ready", int'(bus_if.tx_ready), 1);
        reset = 1'b1;
        repeat (2) @(negedge baud_clk);

        foreach (tbl[i]) begin
            send(tbl[i].data, tbl[i].par_even ^ 1'(PODD), tbl[i].glitch_at);
            $display("vector %0d: byte %02h glitch_at %0d done at cycle %0d", i, tbl[i].data,
                     tbl[i].glitch_at, last_done_cyc);
        end

        // Held tx_valid across two frames: one idle cycle, done pulses FRAME+1 apart.
        @(negedge baud_clk);
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'h00;
        @(posedge baud_clk);
        check_frame(8'h00, par_model(8'h00), 1'b1, 8'hFF, -1);
        tx_q.push_back(8'h00);
        done1 = last_done_cyc;
        @(posedge baud_clk);
        check_frame(8'hFF, par_model(8'hFF), 1'b0, 8'h00, -1);
        tx_q.push_back(8'hFF);
        check("b2b_done_gap", last_done_cyc - done1, FRAME + 1);
        $display("back-to-back: 00 then FF, done gap %0d cycles", last_done_cyc - done1);

        // Mid-frame reset at cycle 70.
        @(negedge baud_clk);
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'h96;
        @(posedge baud_clk);
        @(negedge baud_clk);
        bus_if.tx_valid = 1'b0;
        repeat (69) @(negedge baud_clk);
        check("pre_reset_busy", int'(tx_busy), 1);
        reset = 1'b0;
        #1;
        check("abort_dout", int'(dout), 1);
        check("abort_busy", int'(tx_busy), 0);
        check("abort_ready", int'(bus_if.tx_ready), 1);
        bad_done = 0;
        repeat (3) begin
            @(negedge baud_clk);
            if (tx_done !== 1'b0 || dout !== 1'b1) bad_done++;
        end
        reset = 1'b1;
        repeat (20) begin
            @(negedge baud_clk);
            if (tx_done !== 1'b0 || dout !== 1'b1) bad_done++;
        end
        check("abort_no_done_cycles", bad_done, 0);
        $display("reset abort: byte 96 dropped at cycle 70");
        send(8'h3C, par_model(8'h3C), -1);
        $display("after reset: byte 3C done at cycle %0d", last_done_cyc);

        // Randomized bytes with random idle gaps.
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge baud_clk);
            send(d, par_model(d), -1);
            $display("random %0d: byte %02h done at cycle %0d", i, d, last_done_cyc);
        end

        repeat (40) @(negedge baud_clk);
        check("rx_count", rx_q.size(), tx_q.size());
        for (int i = 0; i < tx_q.size() && i < rx_q.size(); i++)
            check($sformatf("rx_byte%0d", i), int'(rx_q[i]), int'(tx_q[i]));
        check("rx_stop_errors", rx_stop_err, 0);
        check("rx_parity_errors", rx_par_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
